dual_ram_be: RTL and testbench

Parametrised simple dual-port RAM: one write port, one read port, single clock. It is the successor to the basic dual-port RAM and adds byte-write enables, a selectable read latency (1 or 2), a selectable read-during-write policy and a read-valid strobe. Memory is cleared by a sequential init engine after reset instead of an in-cycle array clear. It sits in datapath buffers and register files that need partial-word updates.

---
 rtl/dual_ram_be.sv | 169 ++++++++++++++++
 tb/tb_dual_ram_be.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_ram_be.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle registered read, selectable
// read-during-write policy and a post-reset sequential clear of the whole array.
module dual_ram_be #(
  parameter int RAM_WIDTH  = 32,
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_SIZE  = 4,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write,
  input  logic [ADDR_SIZE-1:0]   wr_addr,
  input  logic [RAM_WIDTH/8-1:0] wr_be,
  input  logic [RAM_WIDTH-1:0]   data_in,
  input  logic                   read,
  input  logic [ADDR_SIZE-1:0]   rd_addr,
  output logic [RAM_WIDTH-1:0]   data_out,
  output logic                   rd_valid,
  output logic                   init_busy
);

  localparam int NB    = RAM_WIDTH / 8;
  localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0] DEPTH_CMP = (ADDR_SIZE+1)'(RAM_DEPTH);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(RAM_DEPTH - 1);

  if ((RAM_WIDTH % 8) != 0 || RAM_WIDTH < 8) begin : g_bad_width
    $error("dual_ram_be: RAM_WIDTH must be a non-zero multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("dual_ram_be: RD_LATENCY must be 1 or 2");
  end
  if (ADDR_SIZE < 1 || RAM_DEPTH < 1 || (1 << ADDR_SIZE) < RAM_DEPTH) begin : g_bad_depth
    $error("dual_ram_be: 2**ADDR_SIZE must cover RAM_DEPTH");
  end

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             init_busy_q, init_busy_d;
  logic             clear_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_busy_q <= init_busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_busy_d = init_busy_q;
    clear_en    = 1'b0;
    case (state_q)
      ST_INIT: begin
        clear_en  = 1'b1;
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d     = ST_READY;
          init_busy_d = 1'b0;
          clr_cnt_d   = '0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign init_busy = init_busy_q;

  logic             wr_in_range, rd_in_range;
  logic             wr_acc, rd_acc, same_addr;
  logic [IDX_W-1:0] mem_wr_idx, rd_idx;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_CMP);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_CMP);
  assign wr_acc      = (state_q == ST_READY) && write && wr_in_range;
  assign rd_acc      = (state_q == ST_READY) && read;
  assign same_addr   = wr_acc && (wr_addr == rd_addr);
  // The clear engine owns the write port for the whole INIT window.
  assign mem_wr_idx  = clear_en ? clr_cnt_q : wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];

  logic [RAM_WIDTH-1:0] stage1_word;
  logic                 rd_vld1_q;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_mem [RAM_DEPTH];
    logic       lane_we;
    logic [7:0] lane_wdata;
    logic [7:0] lane_rd;
    logic [7:0] lane_q;

    assign lane_we    = clear_en || (wr_acc && wr_be[gi]);
    assign lane_wdata = clear_en ? 8'h00 : data_in[8*gi +: 8];

    always_ff @(posedge clk) begin
      if (lane_we) begin
        lane_mem[mem_wr_idx] <= lane_wdata;
      end
    end

    // Write-first bypass only for lanes actually being written this edge.
    always_comb begin
      lane_rd = 8'h00;
      if (rd_in_range) begin
        if (RDW_MODE == 1 && same_addr && wr_be[gi]) begin
          lane_rd = data_in[8*gi +: 8];
        end else begin
          lane_rd = lane_mem[rd_idx];
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lane_q <= 8'h00;
      end else if (rd_acc) begin
        lane_q <= lane_rd;
      end
    end

    assign stage1_word[8*gi +: 8] = lane_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld1_q <= 1'b0;
    end else begin
      rd_vld1_q <= rd_acc;
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign data_out = stage1_word;
    assign rd_valid = rd_vld1_q;
  end else begin : g_lat2
    logic [RAM_WIDTH-1:0] data2_q;
    logic                 vld2_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data2_q <= '0;
        vld2_q  <= 1'b0;
      end else begin
        vld2_q <= rd_vld1_q;
        if (rd_vld1_q) begin
          data2_q <= stage1_word;
        end
      end
    end

    assign data_out = data2_q;
    assign rd_valid = vld2_q;
  end

endmodule

// File: tb/tb_dual_ram_be.sv
// Bench for dual_ram_be: three configurations driven in lockstep, checked against a
// behavioural memory model through per-instance result queues.
module tb_dual_ram_be;

  localparam int DEP [3] = '{16, 16, 12};
  localparam int LAT [3] = '{1, 2, 1};
  localparam int RDW [3] = '{0, 1, 1};

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        w;
    logic [3:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        r;
    logic [3:0]  ra;
    logic [31:0] exp0;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        write;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] data_in;
  logic        read;
  logic [3:0]  rd_addr;
  logic [31:0] dout [3];
  logic        vld  [3];
  logic        busy [3];

  exp_t        sbq [3][$];
  logic [31:0] mdl [3][16];
  logic [31:0] last_exp [3];
  vec_t        tbl [21];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          since_rst = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dual_ram_be #(.RAM_WIDTH(32), .RAM_DEPTH(16), .ADDR_SIZE(4), .RD_LATENCY(1), .RDW_MODE(0)) u0 (
    .clk(clk), .reset(reset_n), .write(write), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .read(read), .rd_addr(rd_addr),
    .data_out(dout[0]), .rd_valid(vld[0]), .init_busy(busy[0]));

  dual_ram_be #(.RAM_WIDTH(32), .RAM_DEPTH(16), .ADDR_SIZE(4), .RD_LATENCY(2), .RDW_MODE(1)) u1 (
    .clk(clk), .reset(reset_n), .write(write), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .read(read), .rd_addr(rd_addr),
    .data_out(dout[1]), .rd_valid(vld[1]), .init_busy(busy[1]));

  dual_ram_be #(.RAM_WIDTH(32), .RAM_DEPTH(12), .ADDR_SIZE(4), .RD_LATENCY(1), .RDW_MODE(1)) u2 (
    .clk(clk), .reset(reset_n), .write(write), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .read(read), .rd_addr(rd_addr),
    .data_out(dout[2]), .rd_valid(vld[2]), .init_busy(busy[2]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic monitor();
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      if (vld[i]) begin
        n_vec++;
        if (sbq[i].size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_valid u%0d cyc %0d: data_out %h, required no result", i, cyc, dout[i]);
        end else begin
          e = sbq[i].pop_front();
          last_exp[i] = e.data;
          if (dout[i] !== e.data || e.due != cyc) begin
            n_miss++;
            $display("FAIL read u%0d: got %h at cyc %0d, required %h at cyc %0d", i, dout[i], cyc, e.data, e.due);
          end else begin
            $display("ok   read u%0d cyc %0d: %h", i, cyc, dout[i]);
          end
        end
      end else if (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
        n_vec++;
        n_miss++;
        e = sbq[i].pop_front();
        $display("FAIL missing_valid u%0d cyc %0d: rd_valid 0, required %h at cyc %0d", i, cyc, e.data, e.due);
      end
    end
  endtask

  // One clock of stimulus; model is updated read-before-write to express the same-edge policy.
  task automatic step(input logic w, input logic [3:0] wa, input logic [3:0] be, input logic [31:0] wd,
                      input logic r, input logic [3:0] ra, input bit use0, input logic [31:0] exp0);
    exp_t        e;
    logic [31:0] v;
    write = w; wr_addr = wa; wr_be = be; data_in = wd; read = r; rd_addr = ra;
    for (int i = 0; i < 3; i++) begin
      if (since_rst >= DEP[i]) begin
        if (r) begin
          v = (int'(ra) < DEP[i]) ? mdl[i][ra] : 32'h0;
          if (RDW[i] == 1 && w && wa == ra && int'(ra) < DEP[i]) begin
            for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
          end
          if (i == 0 && use0) v = exp0;
          e.data = v;
          e.due  = cyc + LAT[i];
          sbq[i].push_back(e);
        end
        if (w && int'(wa) < DEP[i]) begin
          for (int b = 0; b < 4; b++) if (be[b]) mdl[i][wa][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
    @(posedge clk);
    since_rst++;
    @(negedge clk);
    monitor();
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    since_rst = 0;
    for (int i = 0; i < 3; i++) begin
      for (int a = 0; a < 16; a++) mdl[i][a] = 32'h0;
      chk($sformatf("busy_after_release u%0d", i), {31'b0, busy[i]}, 32'd1);
    end
  endtask

  task automatic init_window(input bit poke);
    for (int k = 1; k <= 16; k++) begin
      if (poke && k <= 12) step(1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 1'b1, 4'd3, 1'b0, 32'h0);
      else idle();
      for (int i = 0; i < 3; i++) begin
        if (k == DEP[i] - 1 || k == DEP[i])
          chk($sformatf("init_busy u%0d edge %0d", i, k), {31'b0, busy[i]}, (k < DEP[i]) ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(a), 1'b0, 32'h0);
    repeat (3) idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 4'd5,  4'hF, 32'h11223344, 1'b0, 4'd0,  32'h0};
    tbl[1]  = '{1'b1, 4'd5,  4'h5, 32'hAABBCCDD, 1'b0, 4'd0,  32'h0};
    tbl[2]  = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd5,  32'h11BB33DD};
    tbl[3]  = '{1'b1, 4'd5,  4'h0, 32'hFFFFFFFF, 1'b1, 4'd5,  32'h11BB33DD};
    tbl[4]  = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd5,  32'h11BB33DD};
    tbl[5]  = '{1'b1, 4'd7,  4'hF, 32'h01020304, 1'b0, 4'd0,  32'h0};
    tbl[6]  = '{1'b1, 4'd7,  4'hC, 32'hF0F0F0F0, 1'b1, 4'd7,  32'h01020304};
    tbl[7]  = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd7,  32'hF0F00304};
    tbl[8]  = '{1'b1, 4'd2,  4'hF, 32'h0000A5A5, 1'b1, 4'd1,  32'h0};
    tbl[9]  = '{1'b1, 4'd1,  4'h2, 32'h12345678, 1'b1, 4'd2,  32'h0000A5A5};
    tbl[10] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd1,  32'h00005600};
    tbl[11] = '{1'b1, 4'd13, 4'hF, 32'hDEADBEEF, 1'b1, 4'd13, 32'h0};
    tbl[12] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd13, 32'hDEADBEEF};
    tbl[13] = '{1'b1, 4'd11, 4'h8, 32'h99000000, 1'b1, 4'd11, 32'h0};
    tbl[14] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd11, 32'h99000000};
    tbl[15] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd0,  32'h0};
    tbl[16] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd15, 32'h0};
    tbl[17] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd1,  32'h00005600};
    tbl[18] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd2,  32'h0000A5A5};
    tbl[19] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd3,  32'h0};
    tbl[20] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd5,  32'h11BB33DD};

    reset_n = 1'b0; write = 1'b0; wr_addr = '0; wr_be = '0; data_in = '0; read = 1'b0; rd_addr = '0;
    for (int i = 0; i < 3; i++) last_exp[i] = 32'h0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset data_out u%0d", i), dout[i], 32'h0);
      chk($sformatf("reset rd_valid u%0d", i), {31'b0, vld[i]}, 32'd0);
      chk($sformatf("reset init_busy u%0d", i), {31'b0, busy[i]}, 32'd1);
    end

    release_reset();
    init_window(1'b1);
    read_all();

    for (int t = 0; t < 21; t++) begin
      step(tbl[t].w, tbl[t].wa, tbl[t].be, tbl[t].wd, tbl[t].r, tbl[t].ra, tbl[t].r, tbl[t].exp0);
    end
    repeat (3) idle();
    for (int i = 0; i < 3; i++) chk($sformatf("hold data_out u%0d", i), dout[i], last_exp[i]);

    // Reset lands while u1 still has its second read in the pipeline.
    step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd5, 1'b0, 32'h0);
    step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd7, 1'b0, 32'h0);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_reset data_out u%0d", i), dout[i], 32'h0);
      chk($sformatf("async_reset rd_valid u%0d", i), {31'b0, vld[i]}, 32'd0);
      sbq[i].delete();
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("async_reset init_busy u%0d", i), {31'b0, busy[i]}, 32'd1);

    release_reset();
    init_window(1'b0);
    read_all();

    for (int i = 0; i < 3; i++) chk($sformatf("drained u%0d", i), sbq[i].size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
